// File: rtl/adder_inverse_pkg.sv
// Shared types and default sizing for the sequential adder inverse.
package adder_inverse_pkg;
  localparam int ADDINV_W    = 16;
  localparam int ADDINV_D    = 4;
  localparam int ADDINV_NDIG = ADDINV_W / ADDINV_D;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int ADDINV_IDXW = idx_w(ADDINV_NDIG);

  typedef enum logic [1:0] {IDLE, CALC, HOLD} state_t;
endpackage

// File: rtl/adder_inverse_seq_digit_sub.sv
// One D-bit subtract digit with borrow chain: {bout,d} = a - b - bin.
module digit_sub #(
  parameter int D = 4
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  input  logic         bin,
  output logic [D-1:0] d,
  output logic         bout
);
  logic [D:0] diff;

  assign diff      = {1'b0, a} - {1'b0, b} - {{D{1'b0}}, bin};
  assign {bout, d} = diff;
endmodule

// File: rtl/adder_inverse_seq.sv
// Recovers A = S - B - cin one digit per cycle behind valid/ready.
// ADDER_INVERSE_SEQ_CHECK_EN builds the unreachable-sum check on out_err.
module adder_inverse_seq
  import adder_inverse_pkg::*;
#(
  parameter int W = ADDINV_W,
  parameter int D = ADDINV_D
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W:0]   in_sum,
  input  logic [W-1:0] in_b,
  input  logic         in_cin,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_a,
  output logic         out_err
);
  localparam int NDIG = W / D;
  localparam int IW   = idx_w(NDIG);

  state_t state, state_n;

  logic [NDIG-1:0][D-1:0] sum_q, b_q, res_q;
  logic [IW-1:0]          idx;
  logic                   borrow;
  logic [D-1:0]           dig_d;
  logic                   dig_bout;
  logic                   accept, last;

  assign accept = in_valid & in_ready;
  assign last   = (idx == IW'(NDIG - 1));

  // single subtractor, walked across the latched digits by idx
  digit_sub #(.D(D)) u_digit (
    .a    (sum_q[idx]),
    .b    (b_q[idx]),
    .bin  (borrow),
    .d    (dig_d),
    .bout (dig_bout)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (accept)    state_n = CALC;
      CALC:    if (last)      state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default:                state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      in_ready <= 1'b0;
      sum_q    <= '0;
      b_q      <= '0;
      res_q    <= '0;
      idx      <= '0;
      borrow   <= 1'b0;
    end else begin
      state    <= state_n;
      // registered so ready is low throughout reset and never sees out_ready
      in_ready <= (state_n == IDLE);
      case (state)
        IDLE: if (accept) begin
          sum_q  <= in_sum[W-1:0];
          b_q    <= in_b;
          borrow <= in_cin;
          idx    <= '0;
          res_q  <= '0;
        end
        CALC: begin
          res_q[idx] <= dig_d;
          if (!last) begin
            borrow <= dig_bout;
            idx    <= idx + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign out_valid = (state == HOLD);
  assign out_a     = res_q;

`ifdef ADDER_INVERSE_SEQ_CHECK_EN
  logic sum_msb, err_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sum_msb <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (state == IDLE && accept) sum_msb <= in_sum[W];
      if (state == CALC && last)   err_q   <= sum_msb ^ dig_bout;
      if (state == HOLD && out_ready) err_q <= 1'b0;
    end
  end

  assign out_err = err_q;
`else
  assign out_err = 1'b0;
`endif
endmodule

// File: tb/tb_adder_inverse_seq.sv
// Self-checking bench for adder_inverse_seq: directed table, corner sequences, random vs model.
module tb_adder_inverse_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready;
  logic [16:0] in_sum;
  logic [15:0] in_b;
  logic        in_cin;
  logic        out_valid, out_ready;
  logic [15:0] out_a;
  logic        out_err;

  int total = 0;
  int bad   = 0;

  adder_inverse_seq dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_sum(in_sum), .in_b(in_b), .in_cin(in_cin),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .out_err(out_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [16:0] s;
    logic [15:0] b;
    logic        c;
    logic [15:0] a;
    logic        err;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  function automatic logic err_exp(input logic e);
`ifdef ADDER_INVERSE_SEQ_CHECK_EN
    return e;
`else
    return 1'b0;
`endif
  endfunction

  // A is whatever makes A+B+cin match S mod 2^16; the sum is reachable only
  // if the full 17-bit A+B+cin reproduces S exactly
  task automatic model(input logic [16:0] s, input logic [15:0] b, input logic c,
                       output logic [15:0] a, output logic err);
    int unsigned full;
    a    = 16'((int'(s[15:0]) - int'(b) - int'(c)) & 32'hFFFF);
    full = int'(a) + int'(b) + int'(c);
    err  = err_exp(full != int'(s));
  endtask

  task automatic handshake(input logic [16:0] s, input logic [15:0] b, input logic c);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) chk("ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_sum = s; in_b = b; in_cin = c;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_sum = 17'($urandom); in_b = 16'($urandom); in_cin = 1'($urandom);
  endtask

  // called just after the handshake edge; returns cycles until out_valid
  task automatic wait_result(output int lat);
    lat = 0;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic release_out();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic run_req(input string name, input logic [16:0] s, input logic [15:0] b,
                         input logic c, input logic [15:0] ea, input logic ee);
    int lat;
    handshake(s, b, c);
    wait_result(lat);
    chk({name, "_lat"}, lat, 5);
    chk({name, "_a"}, 32'(out_a), 32'(ea));
    chk({name, "_err"}, 32'(out_err), 32'(ee));
    release_out();
  endtask

  vec_t vecs[4];

  initial begin
    logic [15:0] ea, a_hold;
    logic        ee;
    logic [16:0] rs;
    logic [15:0] rb;
    logic        rc;
    int          lat, seen;

    rst = 1'b1; in_valid = 1'b0; in_sum = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b0;
    vecs[0] = '{17'h0_1234, 16'h0234, 1'b0, 16'h1000, 1'b0};
    vecs[1] = '{17'h1_0000, 16'hFFFF, 1'b1, 16'h0000, 1'b0};
    vecs[2] = '{17'h0_0000, 16'h0001, 1'b0, 16'hFFFF, err_exp(1'b1)};
    vecs[3] = '{17'h1_FFFF, 16'h0000, 1'b1, 16'hFFFE, err_exp(1'b1)};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_a", 32'(out_a), 0);
    chk("rst_out_err", 32'(out_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_in_ready", 32'(in_ready), 1);

    foreach (vecs[i]) run_req($sformatf("vec%0d", i), vecs[i].s, vecs[i].b, vecs[i].c,
                              vecs[i].a, vecs[i].err);

    // backpressure with input noise, then an out_ready pulse coincident with a new request
    handshake(17'h0_ABCD, 16'h1111, 1'b0);
    wait_result(lat);
    chk("bp_lat", lat, 5);
    a_hold = out_a;
    chk("bp_a", 32'(a_hold), 32'h9ABC);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom); in_sum = 17'($urandom);
      @(negedge clk);
      if (out_a !== a_hold || in_ready !== 1'b0 || out_valid !== 1'b1) begin
        chk("bp_stable", {out_a, 7'd0, in_ready, 7'd0, out_valid}, {a_hold, 16'h0001});
      end
    end
    chk("bp_stable_end", 32'(out_a), 32'(a_hold));
    out_ready = 1'b1; in_valid = 1'b1; in_sum = 17'h0_5555; in_b = 16'h1234; in_cin = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("coinc_idle_ready", {31'd0, in_ready}, 1);
    chk("coinc_idle_valid", {31'd0, out_valid}, 0);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    model(17'h0_5555, 16'h1234, 1'b1, ea, ee);
    wait_result(lat);
    chk("coinc_lat", lat, 5);
    chk("coinc_a", 32'(out_a), 32'h4320);
    chk("coinc_err", 32'(out_err), 32'(ee));
    release_out();

    // reset during CALC cycle 2
    handshake(17'h0_FFFF, 16'h0001, 1'b0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_valid", 32'(out_valid), 0);
    chk("midrst_a", 32'(out_a), 0);
    chk("midrst_err", 32'(out_err), 0);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_ready", 32'(in_ready), 1);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    chk("midrst_no_valid", seen, 0);
    run_req("midrst_fresh", 17'h0_FFFF, 16'h0001, 1'b0, 16'hFFFE, 1'b0);

    // random requests against the model, with random backpressure
    for (int i = 0; i < 200; i++) begin
      rs = 17'($urandom); rb = 16'($urandom); rc = 1'($urandom);
      if (i % 8 == 0) rs[16] = 1'b1;
      model(rs, rb, rc, ea, ee);
      handshake(rs, rb, rc);
      wait_result(lat);
      repeat ($urandom_range(0, 2)) @(negedge clk);
      chk("rnd_lat", lat, 5);
      chk("rnd_a", 32'(out_a), 32'(ea));
      chk("rnd_err", 32'(out_err), 32'(ee));
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end
endmodule
